pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning program-counter width in bits (legal range 4..32).
REQ-002 SHALL have parameter STACK_DEPTH, default 4, meaning the number of return-address entries (legal range 1..16).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port op  input  3  operation code, typed pc_op_e.
REQ-006 SHALL have port data  input  ADDR_W  jump/call target, or branch offset (two's complement).
REQ-007 SHALL have port stall  input  1  when high, no state changes.
REQ-008 SHALL have port pc  output  ADDR_W  current program counter, registered.
REQ-009 SHALL have port depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
REQ-010 SHALL have port stack_full  output  1  high when depth == STACK_DEPTH.
REQ-011 SHALL have port stack_empty  output  1  high when depth == 0.
REQ-012 SHALL have port ovf_err  output  1  sticky flag for a CALL attempted while the stack is full.
REQ-013 SHALL have port unf_err  output  1  sticky flag for a RET attempted while the stack is empty.

Function
REQ-014 SHALL decode op as follows: NOP=0, INCR=1, LOAD=2, BRANCH=3, CALL=4, RET=5; codes 6 and 7 SHALL act as NOP.
REQ-015 SHALL give every update one-cycle latency: op sampled at edge N is visible on pc/depth/flags after edge N.
REQ-016 SHALL implement NOP as pc held.
REQ-017 SHALL implement INCR as pc <= pc+1, modulo 2^ADDR_W (0xFF -> 0x00 at ADDR_W=8).
REQ-018 SHALL implement LOAD as pc <= data.
REQ-019 SHALL implement BRANCH as pc <= pc + data, with data treated as signed and the result taken modulo 2^ADDR_W.
REQ-020 SHALL implement CALL when the stack is not full as: push (pc+1) mod 2^ADDR_W, pc <= data, depth+1.
REQ-021 SHALL implement CALL when the stack is full as: pc held, stack and depth unchanged, ovf_err <= 1.
REQ-022 SHALL implement RET when the stack is not empty as: pc <= top entry, pop, depth-1.
REQ-023 SHALL implement RET when the stack is empty as: pc held, unf_err <= 1.
REQ-024 SHALL give stall priority over op: stall high means pc, stack, depth and flags all hold, and no error is flagged.
REQ-025 SHALL keep ovf_err and unf_err set until reset; nothing else clears them.
REQ-026 SHALL derive stack_full and stack_empty combinationally from the registered depth.
REQ-027 SHALL require a STACK_DEPTH-deep call nest followed by STACK_DEPTH returns to restore every return address in LIFO order.

Reset
REQ-028 SHALL apply reset synchronously: at a rising clk edge with reset high, pc=0, depth=0, ovf_err=0 and unf_err=0; hence stack_empty=1 and stack_full=0.
REQ-029 SHALL give reset priority over stall and op.
REQ-030 SHALL discard stack contents on reset; entry storage need not be cleared, but it SHALL never be observable while depth is 0.
REQ-031 SHALL abandon any in-flight call nesting on reset mid-sequence; the first RET after reset SHALL set unf_err.

Structure
REQ-032 SHALL place enum pc_op_e (3 bits) and the op-code constants in shared package pc_pkg.
REQ-033 SHALL implement the return stack as one sub-module, pc_ret_stack, parameterised by ADDR_W and STACK_DEPTH, with push/pop/top/depth ports and no error logic.
REQ-034 SHALL keep the error and priority decisions in pc_unit.

Verification
REQ-035 SHALL cover reset and wrap: reset, LOAD 0xFE, INCR, INCR -> pc = 0xFE, 0xFF, 0x00.
REQ-036 SHALL cover branch: pc=0x10; BRANCH 0xFC -> pc=0x0C; BRANCH 0x05 -> pc=0x11; pc=0xFE, BRANCH 0x04 -> pc=0x02.
REQ-037 SHALL cover call/return nesting: pc=0x20; CALL 0x40, CALL 0x60 -> depth=2, pc=0x60; RET -> pc=0x41; RET -> pc=0x21, stack_empty=1.
REQ-038 SHALL cover overflow: 4 CALLs (depth 4, stack_full=1), then a 5th CALL 0x99 -> pc unchanged, depth=4, ovf_err=1; then 4 RETs return correct addresses and ovf_err stays 1.
REQ-039 SHALL cover underflow and stall: stall=1 with RET on an empty stack -> no change, unf_err=0; stall=0 with RET -> unf_err=1, pc held.
REQ-040 SHALL cover reset mid-nest: 2 CALLs, then reset together with op=CALL -> pc=0, depth=0, flags 0; then RET -> unf_err=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared op codes for the program-counter unit.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_INCR   = 3'd1,
        OP_LOAD   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } pc_op_e;

    localparam int PC_OP_W = 3;

endpackage

// File: rtl/pc_unit_if.sv
// Operation/status bundle between a sequencer (master) and pc_unit (slave).
interface pc_unit_if #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
);
    import pc_pkg::*;

    localparam int DW = $clog2(STACK_DEPTH + 1);

    pc_op_e              op;
    logic [ADDR_W-1:0]   data;
    logic                stall;
    logic [ADDR_W-1:0]   pc;
    logic [DW-1:0]       depth;
    logic                stack_full;
    logic                stack_empty;
    logic                ovf_err;
    logic                unf_err;

    modport master (
        output op, data, stall,
        input  pc, depth, stack_full, stack_empty, ovf_err, unf_err
    );

    modport slave (
        input  op, data, stall,
        output pc, depth, stack_full, stack_empty, ovf_err, unf_err
    );

endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. Caller guarantees no push when full and no pop when
// empty; this block holds no error logic.
module pc_ret_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  push_data,
    output logic [ADDR_W-1:0]                  top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // Storage is padded to a power of two so every index value is in range.
    logic [ADDR_W-1:0] mem [0:(1<<IW)-1];
    logic [DW-1:0]     cnt;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;

    assign wr_idx = IW'(cnt);
    assign rd_idx = IW'(cnt - DW'(1));
    assign depth  = cnt;
    // Stale entries are masked so nothing leaks out while the stack is empty.
    assign top    = (cnt == '0) ? '0 : mem[rd_idx];

    // Count/storage update; reset only drops the count, entries stay stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (push) begin
            mem[wr_idx] <= push_data;
            cnt         <= cnt + DW'(1);
        end else if (pop) begin
            cnt <= cnt - DW'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with call/return stack and sticky overflow/underflow flags.
module pc_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    pc_unit_if.slave bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q;
    logic              ovf_q;
    logic              unf_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stk_top;
    logic [DW-1:0]     stk_depth;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign full   = (stk_depth == DW'(STACK_DEPTH));
    assign empty  = (stk_depth == '0);

    // Stack moves only on a legal, unstalled CALL/RET; the stack itself
    // handles reset.
    assign push = !stall_or_reset() && (bus.op == OP_CALL) && !full;
    assign pop  = !stall_or_reset() && (bus.op == OP_RET)  && !empty;

    function automatic logic stall_or_reset();
        return reset || bus.stall;
    endfunction

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .depth     (stk_depth)
    );

    // PC and error flags: reset beats stall, stall beats op.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!bus.stall) begin
            case (bus.op)
                OP_INCR:   pc_q <= pc_inc;
                OP_LOAD:   pc_q <= bus.data;
                // Modular add makes a two's-complement offset work unchanged.
                OP_BRANCH: pc_q <= pc_q + bus.data;
                OP_CALL: begin
                    if (full) ovf_q <= 1'b1;
                    else      pc_q  <= bus.data;
                end
                OP_RET: begin
                    if (empty) unf_q <= 1'b1;
                    else       pc_q  <= stk_top;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.depth       = stk_depth;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.ovf_err     = ovf_q;
    assign bus.unf_err     = unf_q;

endmodule
